// File: rtl/cpu10_pkg.sv
// cpu10_pkg: definitions shared by the 10-bit CPU control blocks.
// Holds the fetch FSM state encodings, the default address and instruction
// widths, the halt encoding and the opcode field layout.
package cpu10_pkg;

  localparam int ADDR_WIDTH_DEF  = 10;
  localparam int INSTR_WIDTH_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_PAUSED = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  // The opcode sits in the top four bits of every instruction word.
  localparam int OPCODE_MSB = 9;
  localparam int OPCODE_LSB = 6;

  localparam logic [3:0] OPC_SUB  = 4'h0;
  localparam logic [3:0] OPC_SYS  = 4'h2;
  localparam logic [3:0] OPC_LOAD = 4'hD;

  localparam logic [INSTR_WIDTH_DEF-1:0] HALT_WORD_DEF = 10'b0010000010;

  function automatic logic [3:0] opcode_of(input logic [INSTR_WIDTH_DEF-1:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk    - clock
//   reset  - asynchronous, active-high; clears the count
//   clear  - synchronous clear
//   inc    - add one this cycle (ignored once saturated)
//   count  - current value
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch/run controller for the 10-bit CPU.
// Owns the PC, addresses the instruction ROM, issues each fetched word to the
// datapath with an instr_valid/exec_done handshake, applies redirects, and
// provides run / step / stop / breakpoint control plus a retired counter.
// Ports:
//   clk, reset                  - clock, async active-high reset
//   start, step, stop           - run control requests
//   bp_enable, bp_address       - single-address breakpoint
//   rom_address, rom_read_data  - combinational instruction ROM port
//   instr, instr_valid          - issued word to the datapath
//   exec_done                   - datapath has finished instr
//   redirect_valid, redirect_pc - branch/jump target, taken with exec_done
//   pc, state                   - program counter, FSM encoding
//   halted, bp_hit              - sticky halt flag, paused-on-breakpoint flag
//   retired_count               - saturating count of completed instructions
//
// state   | meaning
// IDLE    | out of reset, waiting for start or step
// FETCH   | one cycle: check ROM word for halt / breakpoint, latch instr
// EXEC    | instr_valid high, waiting for exec_done
// PAUSED  | stopped after step, stop or breakpoint; PC kept
// HALTED  | halt word fetched; only reset leaves
module fetch_sequencer
  import cpu10_pkg::*;
#(
  parameter int                       ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int                       INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0]    RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0]   HALT_WORD   = HALT_WORD_DEF,
  parameter int                       COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   step,
  input  logic                   stop,
  input  logic                   bp_enable,
  input  logic [ADDR_WIDTH-1:0]  bp_address,
  output logic [ADDR_WIDTH-1:0]  rom_address,
  input  logic [INSTR_WIDTH-1:0] rom_read_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  input  logic                   exec_done,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic [2:0]             state,
  output logic                   halted,
  output logic                   bp_hit,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

  state_t st;
  logic   step_mode;
  logic   stop_pending;
  // Set when a breakpoint pause happens so the resume executes the
  // breakpoint instruction instead of pausing on it again.
  logic   bp_skip;

  assign rom_address = pc;
  assign instr_valid = (st == ST_EXEC);
  assign state       = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st           <= ST_IDLE;
      pc           <= RESET_PC;
      instr        <= '0;
      halted       <= 1'b0;
      bp_hit       <= 1'b0;
      step_mode    <= 1'b0;
      stop_pending <= 1'b0;
      bp_skip      <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (start) begin
            st        <= ST_FETCH;
            step_mode <= 1'b0;
          end else if (step) begin
            st        <= ST_FETCH;
            step_mode <= 1'b1;
          end
        end

        ST_FETCH: begin
          if (stop) begin
            stop_pending <= 1'b1;
          end
          if (rom_read_data == HALT_WORD) begin
            st     <= ST_HALTED;
            halted <= 1'b1;
          end else if (bp_enable && (pc == bp_address) && !bp_skip) begin
            st           <= ST_PAUSED;
            bp_hit       <= 1'b1;
            bp_skip      <= 1'b1;
            stop_pending <= 1'b0;
          end else begin
            instr   <= rom_read_data;
            bp_skip <= 1'b0;
            st      <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          if (exec_done) begin
            pc <= redirect_valid ? redirect_pc : (pc + PC_ONE);
            // A stop arriving together with exec_done still pauses here.
            if (step_mode || stop_pending || stop) begin
              st           <= ST_PAUSED;
              stop_pending <= 1'b0;
            end else begin
              st <= ST_FETCH;
            end
          end else if (stop) begin
            stop_pending <= 1'b1;
          end
        end

        ST_PAUSED: begin
          if (start) begin
            st        <= ST_FETCH;
            step_mode <= 1'b0;
            bp_hit    <= 1'b0;
          end else if (step) begin
            st        <= ST_FETCH;
            step_mode <= 1'b1;
            bp_hit    <= 1'b0;
          end
        end

        ST_HALTED: begin
          st <= ST_HALTED;
        end

        default: begin
          st <= ST_IDLE;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH(COUNT_WIDTH)
  ) u_retired (
    .clk  (clk),
    .reset(reset),
    .clear(1'b0),
    .inc  ((st == ST_EXEC) && exec_done),
    .count(retired_count)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scoreboard bench for fetch_sequencer.
// Stimulus pushes the words expected to be issued; a negedge monitor checks
// every cycle of instr_valid against the queue head and pops on exec_done.
module tb_fetch_sequencer;
  import cpu10_pkg::*;

  localparam int AW = 10;
  localparam int IW = 10;
  localparam int CW = 16;
  localparam logic [IW-1:0] HALT = 10'b0010000010;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, step, stop, bp_enable;
  logic [AW-1:0] bp_address;
  logic [AW-1:0] rom_address;
  logic [IW-1:0] rom_read_data;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          exec_done;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] pc;
  logic [2:0]    state;
  logic          halted, bp_hit;
  logic [CW-1:0] retired_count;

  logic [IW-1:0] rom [0:1023];
  logic          ed, redir_en;
  logic [AW-1:0] redir_from, redir_to;

  assign rom_read_data  = rom[rom_address];
  assign exec_done      = ed;
  assign redirect_valid = redir_en && instr_valid && (pc == redir_from);
  assign redirect_pc    = redir_to;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(10'd0),
    .HALT_WORD(HALT), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .step(step), .stop(stop),
    .bp_enable(bp_enable), .bp_address(bp_address),
    .rom_address(rom_address), .rom_read_data(rom_read_data),
    .instr(instr), .instr_valid(instr_valid), .exec_done(exec_done),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc(pc), .state(state), .halted(halted), .bp_hit(bp_hit),
    .retired_count(retired_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [IW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && instr_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_issue: got 0x%0h, expected no issue", instr);
      end else begin
        check("issued_instr", 32'(instr), 32'(exp_q[0]));
        if (exec_done) void'(exp_q.pop_front());
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = IW'(32'h100 + (i % 200));
  endtask

  task automatic do_reset();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    reset = 1'b1;
    start = 1'b0; step = 1'b0; stop = 1'b0;
    ed = 1'b1; redir_en = 1'b0; redir_from = '0; redir_to = '0;
    bp_enable = 1'b0; bp_address = '0;
    clear_rom();
    cycles(1);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    cycles(1);
    step = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      if (state == s) break;
      cycles(1);
    end
    check(name, 32'(state), 32'(s));
  endtask

  task automatic wait_valid(input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      if (instr_valid) break;
      cycles(1);
    end
    check(name, 32'(instr_valid), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_pc"}, 32'(pc), 32'd0);
    check({tag, "_rom_address"}, 32'(rom_address), 32'd0);
    check({tag, "_instr"}, 32'(instr), 32'd0);
    check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_bp_hit"}, 32'(bp_hit), 32'd0);
    check({tag, "_retired"}, 32'(retired_count), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; step = 1'b0; stop = 1'b0;
    ed = 1'b1; redir_en = 1'b0; redir_from = '0; redir_to = '0;
    bp_enable = 1'b0; bp_address = '0;
    clear_rom();
    cycles(1);
    reset = 1'b0;
    check_reset_values("por");

    // Run sub, load, halt with exec_done tied high.
    rom[0] = 10'h001; rom[1] = 10'h350; rom[2] = HALT;
    exp_q.push_back(10'h001);
    exp_q.push_back(10'h350);
    pulse_start();
    wait_state(3'd4, 40, "run_halt_reached");
    check("run_retired", 32'(retired_count), 32'd2);
    check("run_halted", 32'(halted), 32'd1);
    check("run_pc", 32'(pc), 32'd2);

    // Redirect at pc 6 to 11; halts at 8 would mean the redirect was lost.
    do_reset();
    for (int i = 0; i < 8; i++) rom[i] = IW'(32'h100 + i);
    rom[8] = HALT; rom[11] = HALT;
    redir_en = 1'b1; redir_from = 10'd6; redir_to = 10'd11;
    for (int i = 0; i < 7; i++) exp_q.push_back(IW'(32'h100 + i));
    pulse_start();
    wait_state(3'd4, 60, "redir_halt_reached");
    check("redir_rom_address", 32'(rom_address), 32'd11);
    check("redir_retired", 32'(retired_count), 32'd7);

    // Single step from IDLE.
    do_reset();
    rom[0] = 10'h2C3; rom[1] = HALT;
    exp_q.push_back(10'h2C3);
    pulse_step();
    wait_state(3'd3, 20, "step_paused");
    cycles(5);
    check("step_state_held", 32'(state), 32'd3);
    check("step_retired", 32'(retired_count), 32'd1);
    check("step_pc", 32'(pc), 32'd1);

    // PC wrap: step to 1023 via redirect, then step again with no redirect.
    do_reset();
    rom[0] = 10'h0F0; rom[1023] = 10'h30F;
    redir_en = 1'b1; redir_from = 10'd0; redir_to = 10'd1023;
    exp_q.push_back(10'h0F0);
    pulse_step();
    wait_state(3'd3, 20, "wrap_first_pause");
    check("wrap_pc_1023", 32'(pc), 32'd1023);
    exp_q.push_back(10'h30F);
    pulse_step();
    wait_state(3'd3, 20, "wrap_second_pause");
    check("wrap_pc_0", 32'(pc), 32'd0);
    check("wrap_retired", 32'(retired_count), 32'd2);

    // Breakpoint at 5, then resume runs through it.
    do_reset();
    for (int i = 0; i < 10; i++) rom[i] = IW'(32'h200 + i);
    rom[10] = HALT;
    bp_enable = 1'b1; bp_address = 10'd5;
    for (int i = 0; i < 5; i++) exp_q.push_back(IW'(32'h200 + i));
    pulse_start();
    wait_state(3'd3, 40, "bp_paused");
    check("bp_pc", 32'(pc), 32'd5);
    check("bp_hit_set", 32'(bp_hit), 32'd1);
    check("bp_retired", 32'(retired_count), 32'd5);
    for (int i = 5; i < 10; i++) exp_q.push_back(IW'(32'h200 + i));
    pulse_start();
    wait_state(3'd4, 40, "bp_resume_halt");
    check("bp_hit_cleared", 32'(bp_hit), 32'd0);
    check("bp_resume_retired", 32'(retired_count), 32'd10);
    check("bp_resume_pc", 32'(pc), 32'd10);

    // Backpressure with a stop pulse, then stop ignored while paused.
    do_reset();
    rom[0] = 10'h155; rom[1] = 10'h0AA; rom[2] = HALT;
    ed = 1'b0;
    exp_q.push_back(10'h155);
    pulse_start();
    wait_valid(10, "bp_stall_valid");
    cycles(1);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    cycles(1);
    ed = 1'b1;
    cycles(1);
    ed = 1'b0;
    check("stall_state", 32'(state), 32'd3);
    check("stall_retired", 32'(retired_count), 32'd1);
    check("stall_pc", 32'(pc), 32'd1);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    ed = 1'b1;
    exp_q.push_back(10'h0AA);
    pulse_start();
    wait_state(3'd4, 20, "stall_resume_halt");
    check("stall_resume_retired", 32'(retired_count), 32'd2);

    // stop and exec_done in the same cycle.
    do_reset();
    rom[0] = 10'h011; rom[1] = 10'h022; rom[2] = HALT;
    ed = 1'b0;
    exp_q.push_back(10'h011);
    pulse_start();
    wait_valid(10, "same_cycle_valid");
    stop = 1'b1; ed = 1'b1;
    cycles(1);
    stop = 1'b0; ed = 1'b0;
    check("same_cycle_state", 32'(state), 32'd3);
    check("same_cycle_pc", 32'(pc), 32'd1);
    check("same_cycle_retired", 32'(retired_count), 32'd1);

    // Reset while an instruction is live.
    do_reset();
    rom[0] = 10'h111; rom[1] = 10'h222; rom[2] = 10'h333; rom[3] = HALT;
    exp_q.push_back(10'h111);
    exp_q.push_back(10'h222);
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      if (pc == 10'd2) break;
      cycles(1);
    end
    check("midreset_pc_reached", 32'(pc), 32'd2);
    ed = 1'b0;
    wait_valid(10, "midreset_valid");
    check("midreset_instr", 32'(instr), 32'h333);
    check("midreset_retired_before", 32'(retired_count), 32'd2);
    reset = 1'b1;
    ed = 1'b1;
    #1;
    check_reset_values("midreset");
    cycles(1);
    check("midreset_retired_held", 32'(retired_count), 32'd0);
    reset = 1'b0;
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
